// File: rtl/clk_div.sv
`timescale 1ns/1ps
// Purpose: fixed-ratio divider, out is a registered square wave of period F0/F1 clk cycles.
// Latency: first rising edge of out on the HALF-th rising clk edge after rst_n releases.
// Backpressure: none; free-running, no handshake.
module clk_div #(
    parameter int F0 = 50_000_000,
    parameter int F1 = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic out
);

    // Guard the division so a zero F1 reaches the error branch instead of faulting.
    localparam int DIV  = (F1 > 0) ? (F0 / F1) : 0;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;

    if (F1 <= 0 || DIV < 2) begin : g_bad
        $error("clk_div: F1 must be > 0 and F0/F1 must be >= 2 (F0=%0d F1=%0d)", F0, F1);
        assign out = 1'b0;
    end else begin : g_div
        if ((F0 % F1) != 0) begin : g_warn
            $warning("clk_div: F0=%0d not a multiple of F1=%0d, using truncated DIV=%0d", F0, F1, DIV);
        end

        localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
        localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

        logic [CW-1:0] cnt;
        logic          out_q;

        // Phase counter: 0..DIV-1, wraps so no out-of-range states exist.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        // Output toggles only at the half point (rise) and the wrap point (fall);
        // HALF-1 < DIV-1 so the two events never coincide.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q <= 1'b0;
            end else if (cnt == HALF_M1 || cnt == LAST) begin
                out_q <= ~out_q;
            end
        end

        assign out = out_q;
    end

endmodule

// File: tb/tb_clk_div.sv
`timescale 1ns/1ps
module tb_clk_div;

    logic clk;
    logic rst_n;
    logic out4, out2, out5, out3;

    int n_cmp;
    int n_bad;
    int k;          // rising edges seen since the last reset release
    bit chk_en;

    clk_div u_div4 (.clk(clk), .rst_n(rst_n), .out(out4));
    clk_div #(.F0(10), .F1(5))  u_div2 (.clk(clk), .rst_n(rst_n), .out(out2));
    clk_div #(.F0(50), .F1(10)) u_div5 (.clk(clk), .rst_n(rst_n), .out(out5));
    clk_div #(.F0(90), .F1(30)) u_div3 (.clk(clk), .rst_n(rst_n), .out(out3));

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference: a divider of ratio d is high whenever the edge count since
    // release, taken modulo d, has reached d/2.
    function automatic logic model(input int d, input int edges, input logic in_rst);
        if (in_rst) return 1'b0;
        return ((edges % d) >= (d / 2)) ? 1'b1 : 1'b0;
    endfunction

    // Edge count since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    // Continuous comparison of all four dividers against the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            check("div4", out4, model(4, k, !rst_n));
            check("div2", out2, model(2, k, !rst_n));
            check("div5", out5, model(5, k, !rst_n));
            check("div3", out3, model(3, k, !rst_n));
        end
    end

    task automatic release_reset();
        @(negedge clk);
        #0.5 rst_n = 1'b1;
    endtask

    initial begin
        logic [0:5] p4, p2, p5, p3;
        bit found;
        n_cmp  = 0;
        n_bad  = 0;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        p4 = 6'b011001;
        p2 = 6'b101010;
        p5 = 6'b011100;
        p3 = 6'b110110;

        // Reset state, held across several edges.
        repeat (3) @(posedge clk);
        #0.5;
        check("rst_div4", out4, 1'b0);
        check("rst_div2", out2, 1'b0);
        check("rst_div5", out5, 1'b0);
        check("rst_div3", out3, 1'b0);

        // Hand-computed sequences after the first six edges following release.
        release_reset();
        chk_en = 1'b1;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #0.5;
            check("seq_div4", out4, p4[e]);
            check("seq_div2", out2, p2[e]);
            check("seq_div5", out5, p5[e]);
            check("seq_div3", out3, p3[e]);
        end
        // Steady state over more than ten periods of the slowest divider.
        repeat (60) @(posedge clk);

        // Asynchronous reset while the default divider is high.
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (out4 === 1'b1) found = 1'b1;
        end
        check("found_high_div4", found, 1'b1);
        #0.5 rst_n = 1'b0;
        #0.1;
        check("async_rst_div4", out4, 1'b0);
        check("async_rst_div5", out5, 1'b0);
        repeat (2) @(posedge clk);
        release_reset();
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #0.5;
            check("restart_div4", out4, p4[e]);
            check("restart_div5", out5, p5[e]);
        end

        // Randomised reset pulses at arbitrary phases.
        for (int r = 0; r < 10; r++) begin
            repeat ($urandom_range(3, 40)) @(posedge clk);
            @(negedge clk);
            #0.5 rst_n = 1'b0;
            #0.2;
            check("rnd_rst_div4", out4, 1'b0);
            check("rnd_rst_div3", out3, 1'b0);
            repeat ($urandom_range(1, 4)) @(posedge clk);
            release_reset();
        end
        repeat (30) @(posedge clk);

        chk_en = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
